// File: rtl/config_mult_pkg.sv
// Shared types and constants for the config_multiplier operand path.
package config_mult_pkg;

  localparam int unsigned FULL_W = 8;
  localparam int unsigned HALF_W = 4;

  typedef logic [1:0] lane_mask_t;

  typedef enum logic {
    IDLE     = 1'b0,
    LOW_HELD = 1'b1
  } packer_state_t;

  localparam lane_mask_t MASK_FULL  = 2'b11;
  localparam lane_mask_t MASK_LANE0 = 2'b01;

endpackage

// File: rtl/config_lane_reduce.sv
// Reduces a WIDTH-bit signed element to a WIDTH/2-bit two's complement lane.
// CONFIG_PACKER_SAT_EN selects saturation; otherwise the low bits are kept (wrap).
import config_mult_pkg::*;

module config_lane_reduce #(
  parameter int unsigned WIDTH = FULL_W,
  parameter int unsigned HALF  = WIDTH / 2
) (
  input  logic [WIDTH-1:0] elem,
  output logic [HALF-1:0]  lane
);

`ifdef CONFIG_PACKER_SAT_EN
  // Value fits in HALF bits when all bits from the lane sign bit upward agree.
  logic [WIDTH-HALF:0] top;
  assign top = elem[WIDTH-1:HALF-1];

  always_comb begin
    lane = elem[HALF-1:0];
    if (!((&top) || !(|top))) begin
      if (elem[WIDTH-1]) lane = {1'b1, {(HALF-1){1'b0}}};
      else               lane = {1'b0, {(HALF-1){1'b1}}};
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^elem[WIDTH-1:HALF];
  assign lane      = elem[HALF-1:0];
`endif

endmodule

// File: rtl/config_operand_packer.sv
// Streaming operand packer: passes full-width elements or packs two half lanes per word.
// Lane saturation is enabled by defining CONFIG_PACKER_SAT_EN.
import config_mult_pkg::*;

module config_operand_packer #(
  parameter int unsigned WIDTH = FULL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halvedPrecision,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_multiplier,
  input  logic [WIDTH-1:0] in_multiplicand,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_multiplier,
  output logic [WIDTH-1:0] out_multiplicand,
  output logic             out_halvedPrecision,
  output lane_mask_t       out_lane_mask,
  output logic             out_last
);

  localparam int unsigned HW = WIDTH / 2;

  packer_state_t state_q;
  logic          mode_q;
  logic [HW-1:0] held_mr_q, held_md_q;
  logic [HW-1:0] lane_mr, lane_md;
  logic          out_free, flush_pending, accept;

  config_lane_reduce #(.WIDTH(WIDTH), .HALF(HW)) u_reduce_mr (.elem(in_multiplier),   .lane(lane_mr));
  config_lane_reduce #(.WIDTH(WIDTH), .HALF(HW)) u_reduce_md (.elem(in_multiplicand), .lane(lane_md));

  // A full-mode element arriving while a low lane is held must first push that lane out alone.
  assign out_free      = !out_valid || out_ready;
  assign flush_pending = (state_q == LOW_HELD) && in_valid && !halvedPrecision;
  assign in_ready      = out_free && !flush_pending;
  assign accept        = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      mode_q              <= 1'b0;
      held_mr_q           <= '0;
      held_md_q           <= '0;
      out_valid           <= 1'b0;
      out_multiplier      <= '0;
      out_multiplicand    <= '0;
      out_halvedPrecision <= 1'b0;
      out_lane_mask       <= '0;
      out_last            <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            mode_q <= halvedPrecision;
            if (!halvedPrecision) begin
              out_valid           <= 1'b1;
              out_multiplier      <= in_multiplier;
              out_multiplicand    <= in_multiplicand;
              out_halvedPrecision <= 1'b0;
              out_lane_mask       <= MASK_FULL;
              out_last            <= in_last;
            end else if (in_last) begin
              out_valid           <= 1'b1;
              out_multiplier      <= {HW'(0), lane_mr};
              out_multiplicand    <= {HW'(0), lane_md};
              out_halvedPrecision <= 1'b1;
              out_lane_mask       <= MASK_LANE0;
              out_last            <= 1'b1;
            end else begin
              held_mr_q <= lane_mr;
              held_md_q <= lane_md;
              state_q   <= LOW_HELD;
            end
          end
        end
        LOW_HELD: begin
          if (flush_pending && out_free) begin
            out_valid           <= 1'b1;
            out_multiplier      <= {HW'(0), held_mr_q};
            out_multiplicand    <= {HW'(0), held_md_q};
            out_halvedPrecision <= mode_q;
            out_lane_mask       <= MASK_LANE0;
            out_last            <= 1'b0;
            held_mr_q           <= '0;
            held_md_q           <= '0;
            state_q             <= IDLE;
          end else if (accept) begin
            out_valid           <= 1'b1;
            out_multiplier      <= {lane_mr, held_mr_q};
            out_multiplicand    <= {lane_md, held_md_q};
            out_halvedPrecision <= mode_q;
            out_lane_mask       <= MASK_FULL;
            out_last            <= in_last;
            held_mr_q           <= '0;
            held_md_q           <= '0;
            state_q             <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
